mdu_hilo_unit: RTL and testbench

//  Iterative multiply/divide unit for the EX stage, holding the architectural HI/LO pair.

---
 rtl/mdu_hilo_unit.sv | 160 ++++++++++++++++
 tb/tb_mdu_hilo_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO pair.
// Signed ops are done on magnitudes; the sign correction is applied in the last cycle.
`timescale 1ns/1ps
module mdu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, dvs;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [CW-1:0]      cnt;

  // Handshake: a request is taken when start=1 in a cycle where busy=0 and
  // flush=0; anything presented while busy is dropped, the hazard unit stalls.
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  logic               sgn, is_div, neg_res, neg_rem;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_mul, acc_div, prod;
  logic [WIDTH-1:0]   rem_next, quot, rmd, res_hi, res_lo;

  always_comb begin
    sgn     = !op_q[0];
    is_div  = op_q[1];
    neg_res = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_rem = sgn && a_q[WIDTH-1];
    mag_a   = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b   = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;

    // Shift-add: the low half of acc holds the remaining multiplier bits.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, dvs} & {(WIDTH+1){acc[0]}});
    acc_mul = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: the low half of acc shifts dividend bits out and quotient bits in.
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs};
    rem_next  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    acc_div   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_diff[WIDTH]};

    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd  = neg_rem ? -rem : rem;

    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rmd;
        res_lo = quot;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !flush && !op[2]) state_d = S_PREP;
      S_PREP: state_d = flush ? S_IDLE : S_RUN;
      S_RUN: begin
        if (flush)                      state_d = S_IDLE;
        else if (cnt == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      dvs  <= '0;
      acc  <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            if (!op[2]) begin
              op_q <= op[1:0];
              a_q  <= a;
              b_q  <= b;
            end
          end
        end
        S_PREP: begin
          acc <= {{WIDTH{1'b0}}, mag_a};
          dvs <= mag_b;
          rem <= '0;
          cnt <= '0;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= acc_div;
            rem <= rem_next;
          end else begin
            acc <= acc_mul;
          end
        end
        S_FIX: begin
          // A squash arriving in the final cycle still wins over the write.
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: arithmetic reference model feeding an
// expected-result queue, plus directed flush/reset/ignored-start scenarios.
`timescale 1ns/1ps
module tb_mdu_hilo_unit;
  localparam int W = 32;
  localparam int LAT = W + 2;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  mdu_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    res = '0;
    case (o)
      MULT:  res = 64'(sx * sy);
      MULTU: res = ux * uy;
      DIV, DIVU: begin
        if (y == '0) res = {x, {W{1'b1}}};
        else if (o == DIV) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[W-1:0], q[W-1:0]};
        end else begin
          res = {32'(ux % uy), 32'(ux / uy)};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic f);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; flush = f;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
  endtask

  // Waits for done starting n_start edges after the start edge; checks latency,
  // busy held, hi/lo held until the write, the popped result and the done pulse width.
  task automatic wait_result(input string name, input int n_start, input logic [2*W-1:0] prev);
    int n;
    bit got, hold_bad, busy_bad;
    logic [2*W-1:0] exp;
    n = n_start; got = 0; hold_bad = 0; busy_bad = 0;
    while (n < LAT + 6 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1;
      else begin
        if ({hi, lo} !== prev) hold_bad = 1;
        if (busy !== 1'b1) busy_bad = 1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d edges", name, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (n !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, n, LAT);
    end
    checks++;
    if (hold_bad || busy_bad) begin
      errors++;
      $display("FAIL %s hold: hilo_changed=%0d busy_dropped=%0d expected 0 0", name, hold_bad, busy_bad);
    end
    checks++;
    exp = exp_q.pop_front();
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp[2*W-1:W], exp[W-1:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: got %b expected 0", name, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b expected 0 one cycle later", name, done);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] prev;
    prev = {hi, lo};
    exp_q.push_back(model(o, x, y));
    drive_start(o, x, y, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_start: got %b expected 1", name, busy);
    end
    wait_result(name, 0, prev);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    checks++;
    if ({busy, done, hi, lo} !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h st=%0d expected all 0", busy, done, hi, lo, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op("mult_neg", MULT, 32'hFFFF_FFFF, 32'd2);
    run_op("multu_big", MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op("mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    run_op("div_neg", DIV, -32'sd7, 32'd2);
    run_op("divu_small", DIVU, 32'd7, 32'd2);
    run_op("divu_zero", DIVU, 32'd5, 32'd0);
    run_op("div_zero_neg", DIV, -32'sd5, 32'd0);
    run_op("div_overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_negdivisor", DIV, 32'd100, -32'sd7);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'h1234;
    @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'h1234 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: got hi=%h busy=%b expected hi=00001234 busy=0", hi, busy);
    end
    @(negedge clk);
    op = MTLO; a = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected 00001234 00005678 0 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_flush_run();
    logic [2*W-1:0] prev;
    bit saw_done;
    prev = {hi, lo};
    drive_start(DIV, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_run busy: got %b expected 0", busy);
    end
    saw_done = 0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    checks++;
    if ({hi, lo} !== prev || saw_done) begin
      errors++;
      $display("FAIL flush_run hold: got hi=%h lo=%h done_seen=%0d expected hi=%h lo=%h 0",
               hi, lo, saw_done, prev[2*W-1:W], prev[W-1:0]);
    end
  endtask

  task automatic test_flush_fix();
    logic [2*W-1:0] prev;
    prev = {hi, lo};
    drive_start(MULT, 32'd3, 32'd5, 1'b0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++;
    if (state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL flush_fix state: got %0d expected 3", state_dbg);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if ({hi, lo} !== prev || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_fix: got hi=%h lo=%h done=%b busy=%b expected hi=%h lo=%h 0 0",
               hi, lo, done, busy, prev[2*W-1:W], prev[W-1:0]);
    end
  endtask

  task automatic test_flush_start_idle();
    logic [W-1:0] prev_hi;
    prev_hi = hi;
    drive_start(MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    checks++;
    if (hi !== prev_hi || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_mthi: got hi=%h busy=%b expected hi=%h busy=0", hi, busy, prev_hi);
    end
    drive_start(MULT, 32'd9, 32'd9, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_mult: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_start_while_busy();
    logic [2*W-1:0] prev;
    prev = {hi, lo};
    exp_q.push_back(model(MULT, 32'hFFFF_FFF9, 32'd123));
    drive_start(MULT, 32'hFFFF_FFF9, 32'd123, 1'b0);
    repeat (4) @(posedge clk);
    drive_start(MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
    drive_start(MULTU, 32'd77, 32'd88, 1'b0);
    checks++;
    if (hi !== prev[2*W-1:W] || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_ignored: got hi=%h busy=%b expected hi=%h busy=1", hi, busy, prev[2*W-1:W]);
    end
    wait_result("start_while_busy", 6, prev);
  endtask

  task automatic test_back_to_back();
    logic [2:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom();
      y = (i == 5) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom());
      run_op($sformatf("rand%0d_op%0d", i, o), o, x, y);
    end
  endtask

  task automatic test_reset_mid_run();
    drive_start(DIVU, 32'd12345, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h st=%0d expected all 0",
               busy, done, hi, lo, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_discard: got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    run_op("seed_hilo", MULTU, 32'h0001_0001, 32'h0002_0003);
    test_flush_run();
    test_flush_fix();
    test_flush_start_idle();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
